keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of the 4x4 matrix keypad (the other end of the row/column scan protocol).
- Accepts "press key K for N ms" requests over a valid/ready handshake.
- Watches the active-low column drive from the keypad scanner and pulls the matching active-low row line while the emulated contact is closed.
- Used on-board (switch-driven self-test) and in benches to exercise the keypad decoder and downstream display path without a physical keypad.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz; one ms tick = CLK_FREQ/1000 cycles.
- GAP_MS, 5, open-contact time in ms after release before the next request is accepted.
- BOUNCE_CYCLES, 64, length in cycles of each bounce segment (used only with the optional feature).
- BOUNCE_TOGGLES, 4, number of contact toggles per bounce phase; must be even and at least 2 (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_key  in  4  hex key code 0x0-0xF.
- req_hold_ms  in  8  hold duration in ms; 0 is treated as 1.
- col_n  in  4  column drive from the scanner, active-low; bit 0 is the leftmost column.
- row_n  out  4  row return, active-low, 1 = released/pulled up; bit 0 is the top row.
- key_active  out  1  emulated contact currently closed.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values: row_n=4'hF, key_active=0, busy=0, done=0, req_ready=0 during reset and 1 in the first cycle after it.
- Reset mid-operation: row_n returns to 4'hF immediately (asynchronous); the in-flight request is dropped and done is not pulsed.
- Key map (key: row,col):
  - Row 0: 1:0,0; 2:0,1; 3:0,2; A:0,3.
  - Row 1: 4:1,0; 5:1,1; 6:1,2; B:1,3.
  - Row 2: 7:2,0; 8:2,1; 9:2,2; C:2,3.
  - Row 3: 0:3,0; F:3,1; E:3,2; D:3,3.
- Accept: a request is accepted on a cycle with req_valid && req_ready. On that cycle key_row, key_col and the hold count are latched. req_key and req_hold_ms are ignored at all other times.
- FSM states and transitions:
  - IDLE -> PRESS on accept.
  - PRESS -> HOLD once the press bounce completes; immediately (1 cycle) without the feature.
  - HOLD -> RELEASE after hold_ms*CLK_FREQ/1000 cycles. The ms divider restarts on HOLD entry, so the duration is exact.
  - RELEASE -> GAP once the release bounce completes; immediately without the feature.
  - GAP -> IDLE after GAP_MS ms; done pulses on the IDLE-entry cycle.
- Contact: key_active=1 throughout HOLD. During PRESS/RELEASE it follows the bounce pattern (feature) or equals the post-phase value. It is 0 in IDLE and GAP.
- Row drive, registered with 1 cycle latency from col_n: row_n[r] <= ~(key_active && r==key_row && !col_n[key_col]).
  - All other rows stay 1.
  - If several columns are low at once, only the latched column matters.
- col_n is sampled directly. Its settle time is the scanner's responsibility; no synchronizer is included because it is a same-clock on-board path.
- Width rules:
  - hold_ms*CLK_FREQ/1000 is counted as hold_ms ms ticks of a ms divider with $clog2(CLK_FREQ/1000) bits.
  - The hold counter is 8 bits and never wraps; 255 ms maximum.
- Back-to-back: req_valid held high with new data is accepted on the first cycle after done, i.e. the cycle req_ready rises.

Optional Feature:
- Macro: KP_EMU_BOUNCE_EN.
- Defined:
  - The PRESS phase toggles the contact BOUNCE_TOGGLES times, starting closed, each segment BOUNCE_CYCLES long; the phase ends closed.
  - RELEASE mirrors this, starting open and ending open.
  - Total bounce = BOUNCE_TOGGLES*BOUNCE_CYCLES cycles per phase.
- Undefined: clean make/break; PRESS and RELEASE each last exactly 1 cycle. The BOUNCE_* parameters are unused.

Decomposition:
- Package kp_emu_pkg holds:
  - state enum: IDLE, PRESS, HOLD, RELEASE, GAP;
  - the 16-entry key-to-{row,col} constant array, with a lookup function;
  - the KP_ROWS/KP_COLS = 4 constants.
- One sub-module, kp_ms_tick: restartable ms-tick divider parameterized by CLK_FREQ, with a restart input and a one-cycle tick output.

Test Plan (CLK_FREQ=10_000, i.e. 10 cycles/ms; GAP_MS=2):
- Reset asserted mid-HOLD for key 5 -> row_n=4'hF within the same cycle, busy=0, no done pulse, and req_ready=1 on the first cycle after reset release.
- Request key 5, hold 3; scanner drives col_n=4'b1101 continuously -> row_n=4'b1101 starting 2 cycles after accept, lasting 30 cycles; done pulses 20 cycles after release.
- Same request with the scanner rotating col_n through 1110/1101/1011/0111 -> row_n[1]=0 only on the cycle after col_n=1101, else 4'hF.
- Keys 1, A, 0, D, each hold 1 -> correct corners (row,col) = (0,0), (0,3), (3,0), (3,3); req_ready=0 while busy, and each next request is accepted on the req_ready rising cycle.
- req_hold_ms=0 -> behaves as 1 ms (10 cycles of key_active); req_hold_ms=255 -> 2550 cycles, with no counter wrap.
- With KP_EMU_BOUNCE_EN, BOUNCE_CYCLES=4, BOUNCE_TOGGLES=4 -> key_active follows the pattern 1,0,1,0 (4 cycles each) then holds 1; release mirrors this as 0,1,0,1 then holds 0.

Source files
------------

// File: rtl/kp_emu_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: FSM states,
// the key-to-matrix-position map and its lookup.
package kp_emu_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    RELEASE,
    GAP
  } kp_state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } kp_pos_t;

  // Indexed by hex key code; each entry is {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'hC, 4'h0, 4'h1, 4'h2,
    4'h4, 4'h5, 4'h6, 4'h8,
    4'h9, 4'hA, 4'h3, 4'h7,
    4'hB, 4'hF, 4'hE, 4'hD
  };

  function automatic kp_pos_t kp_key_pos(input logic [3:0] key);
    return kp_pos_t'(KEY_MAP[key]);
  endfunction

endpackage

// File: rtl/kp_emu_ms_tick.sv
// Restartable millisecond divider: tick_c is high for one cycle every
// CLK_FREQ/1000 cycles, counted from the last restart.
module kp_ms_tick
  import kp_emu_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned DIV  = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = (cnt_q == LAST);

endmodule

// File: rtl/keypad_emulator.sv
// Emulates the key side of a 4x4 scanned matrix keypad: accepts timed
// key-press requests and returns the active-low row for the latched column.
// Optional contact bounce is enabled with the KP_EMU_BOUNCE_EN macro.
module keypad_emulator
  import kp_emu_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned GAP_MS         = 5,
  parameter int unsigned BOUNCE_CYCLES  = 64,
  parameter int unsigned BOUNCE_TOGGLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_key,
  input  logic [7:0]         req_hold_ms,
  input  logic [KP_COLS-1:0] col_n,
  output logic [KP_ROWS-1:0] row_n,
  output logic               key_active,
  output logic               busy,
  output logic               done
);

  localparam int unsigned GAP_LOAD = (GAP_MS == 0) ? 1 : GAP_MS;

  if (BOUNCE_CYCLES == 0 || BOUNCE_TOGGLES < 2 || (BOUNCE_TOGGLES % 2) != 0) begin : g_cfg_check
    $error("keypad_emulator: BOUNCE_TOGGLES must be even and >= 2, BOUNCE_CYCLES >= 1");
  end

  kp_state_e          state_q, state_d;
  logic [1:0]         key_row_q, key_row_d;
  logic [1:0]         key_col_q, key_col_d;
  logic [7:0]         ms_cnt_q, ms_cnt_d;
  logic               key_active_q, key_active_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               req_ready_q, req_ready_d;
  logic [KP_ROWS-1:0] row_n_q, row_n_d;
  logic               restart_c;
  logic               tick_c;
  kp_pos_t            pos_c;

`ifdef KP_EMU_BOUNCE_EN
  localparam int unsigned BCW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned BSW = $clog2(BOUNCE_TOGGLES);
  localparam logic [BCW-1:0] BCYC_LAST = BCW'(BOUNCE_CYCLES - 1);
  localparam logic [BSW-1:0] BSEG_LAST = BSW'(BOUNCE_TOGGLES - 1);

  logic [BCW-1:0] bcyc_q, bcyc_d;
  logic [BSW-1:0] bseg_q, bseg_d;
  logic           bounce_end_c;
`endif

  kp_ms_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart_c),
    .tick_c (tick_c)
  );

  // Next-state, latched request and registered output computation.
  always_comb begin
    state_d      = state_q;
    key_row_d    = key_row_q;
    key_col_d    = key_col_q;
    ms_cnt_d     = ms_cnt_q;
    done_d       = 1'b0;
    restart_c    = 1'b0;
    pos_c        = kp_key_pos(req_key);
`ifdef KP_EMU_BOUNCE_EN
    bcyc_d       = bcyc_q;
    bseg_d       = bseg_q;
    bounce_end_c = 1'b0;
    if (state_q == PRESS || state_q == RELEASE) begin
      if (bcyc_q == BCYC_LAST) begin
        bcyc_d = '0;
        if (bseg_q == BSEG_LAST) begin
          bounce_end_c = 1'b1;
        end else begin
          bseg_d = bseg_q + BSW'(1);
        end
      end else begin
        bcyc_d = bcyc_q + BCW'(1);
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          key_row_d = pos_c.row;
          key_col_d = pos_c.col;
          ms_cnt_d  = (req_hold_ms == 8'd0) ? 8'd1 : req_hold_ms;
          state_d   = PRESS;
`ifdef KP_EMU_BOUNCE_EN
          bcyc_d    = '0;
          bseg_d    = '0;
`endif
        end
      end
      PRESS: begin
`ifdef KP_EMU_BOUNCE_EN
        if (bounce_end_c) begin
          state_d   = HOLD;
          restart_c = 1'b1;
        end
`else
        state_d   = HOLD;
        restart_c = 1'b1;
`endif
      end
      HOLD: begin
        if (tick_c) begin
          if (ms_cnt_q == 8'd1) begin
            state_d = RELEASE;
`ifdef KP_EMU_BOUNCE_EN
            bcyc_d  = '0;
            bseg_d  = '0;
`endif
          end else begin
            ms_cnt_d = ms_cnt_q - 8'd1;
          end
        end
      end
      RELEASE: begin
`ifdef KP_EMU_BOUNCE_EN
        if (bounce_end_c) begin
          state_d   = GAP;
          ms_cnt_d  = 8'(GAP_LOAD);
          restart_c = 1'b1;
        end
`else
        state_d   = GAP;
        ms_cnt_d  = 8'(GAP_LOAD);
        restart_c = 1'b1;
`endif
      end
      GAP: begin
        if (tick_c) begin
          if (ms_cnt_q == 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bounce segments alternate starting closed on press, open on release.
    case (state_d)
      HOLD:    key_active_d = 1'b1;
`ifdef KP_EMU_BOUNCE_EN
      PRESS:   key_active_d = ~bseg_d[0];
      RELEASE: key_active_d = bseg_d[0];
`endif
      default: key_active_d = 1'b0;
    endcase

    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);

    for (int unsigned r = 0; r < KP_ROWS; r++) begin
      row_n_d[r] = ~(key_active_q && (key_row_q == 2'(r)) && !col_n[key_col_q]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      key_row_q    <= '0;
      key_col_q    <= '0;
      ms_cnt_q     <= '0;
      key_active_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      row_n_q      <= '1;
`ifdef KP_EMU_BOUNCE_EN
      bcyc_q       <= '0;
      bseg_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      key_row_q    <= key_row_d;
      key_col_q    <= key_col_d;
      ms_cnt_q     <= ms_cnt_d;
      key_active_q <= key_active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_ready_q  <= req_ready_d;
      row_n_q      <= row_n_d;
`ifdef KP_EMU_BOUNCE_EN
      bcyc_q       <= bcyc_d;
      bseg_q       <= bseg_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign row_n      = row_n_q;
  assign key_active = key_active_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed scoreboard bench for keypad_emulator at 10 cycles/ms, GAP_MS=2.
module tb_keypad_emulator;

  localparam int CLK_FREQ = 10_000;
  localparam int GAP_MS   = 2;
  localparam int BC       = 4;
  localparam int BT       = 4;
  localparam int CPM      = CLK_FREQ / 1000;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_key;
  logic [7:0] req_hold_ms;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_active;
  logic       busy;
  logic       done;

  keypad_emulator #(
    .CLK_FREQ      (CLK_FREQ),
    .GAP_MS        (GAP_MS),
    .BOUNCE_CYCLES (BC),
    .BOUNCE_TOGGLES(BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_hold_ms(req_hold_ms),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_active (key_active),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         row;
    int         col;
    int         hold_eff;
  } exp_t;

  exp_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] rot_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // Physical layout as printed on the keypad, top row first.
  logic [3:0] grid [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'h0, 4'hF, 4'hE, 4'hD}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [3:0] k, input logic [7:0] h);
    exp_t e;
    e.key = k;
    e.row = -1;
    e.col = -1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (grid[r][c] == k) begin
          e.row = r;
          e.col = c;
        end
    e.hold_eff = (h == 8'd0) ? 1 : int'(h);
    sb.push_back(e);
  endtask

  // Expected contact state s cycles after the accept edge.
  function automatic bit ka_model(input int s, input int h);
    int held;
    held = h * CPM;
`ifdef KP_EMU_BOUNCE_EN
    if (s < 0) return 1'b0;
    if (s < BT * BC) return ((s / BC) % 2) == 0;
    if (s < BT * BC + held) return 1'b1;
    if (s < 2 * BT * BC + held) return (((s - BT * BC - held) / BC) % 2) == 1;
    return 1'b0;
`else
    return (s >= 1) && (s <= held);
`endif
  endfunction

  function automatic int done_model(input int h);
`ifdef KP_EMU_BOUNCE_EN
    return 2 * BT * BC + h * CPM + GAP_MS * CPM;
`else
    return h * CPM + 2 + GAP_MS * CPM;
`endif
  endfunction

  // Called just after an accept edge; follows the request until done.
  task automatic measure(input bit rot, input bit chain, input logic [3:0] nkey, input logic [7:0] nhold);
    exp_t       e;
    int         s, dn, dn_exp, bad_row, bad_ka, bad_busy, bad_ready;
    logic [3:0] prev_col, exp_row;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb[0];
    s = 0; dn = -1; bad_row = 0; bad_ka = 0; bad_busy = 0; bad_ready = 0;
    dn_exp   = done_model(e.hold_eff);
    prev_col = col_n;
    while (s <= dn_exp + 50) begin
      @(negedge clk);
      exp_row = 4'hF;
      if (ka_model(s - 1, e.hold_eff) && !prev_col[e.col]) exp_row[e.row] = 1'b0;
      if (row_n !== exp_row) bad_row++;
      if (key_active !== ka_model(s, e.hold_eff)) bad_ka++;
      if (done === 1'b1) begin
        dn = s;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (req_ready !== 1'b0) bad_ready++;
      if (s == 0) begin
        if (chain) begin
          req_key     = nkey;
          req_hold_ms = nhold;
          push_exp(nkey, nhold);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rot) col_n = rot_pat[(s + 1) % 4];
      prev_col = col_n;
      s++;
    end
    check($sformatf("done_at key%h", e.key), dn, dn_exp);
    check($sformatf("row_n_pattern key%h", e.key), bad_row, 0);
    check($sformatf("key_active_pattern key%h", e.key), bad_ka, 0);
    check($sformatf("busy_while_active key%h", e.key), bad_busy, 0);
    check($sformatf("ready_low_while_busy key%h", e.key), bad_ready, 0);
    check($sformatf("ready_at_done key%h", e.key), req_ready, 1);
    check($sformatf("busy_at_done key%h", e.key), busy, 0);
    void'(sb.pop_front());
  endtask

  task automatic issue(input logic [3:0] k, input logic [7:0] h, input bit rot, input bit chain,
                       input logic [3:0] nkey, input logic [7:0] nhold);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("ready_timeout", 32'd0, 32'd1);
    if (rot) col_n = rot_pat[0];
    req_valid   = 1'b1;
    req_key     = k;
    req_hold_ms = h;
    push_exp(k, h);
    @(posedge clk);
    measure(rot, chain, nkey, nhold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_key = 4'h0; req_hold_ms = 8'd0; col_n = 4'hF;
    repeat (3) @(negedge clk);
    check("reset row_n", row_n, 4'hF);
    check("reset key_active", key_active, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset req_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Key 5 held 3 ms with its column driven low continuously.
    col_n = 4'b1101;
    issue(4'h5, 8'd3, 1'b0, 1'b0, 4'h0, 8'd0);

    // Same request with a rotating column scan.
    issue(4'h5, 8'd3, 1'b1, 1'b0, 4'h0, 8'd0);

    // Reset in the middle of HOLD.
    col_n = 4'b1101;
    @(negedge clk);
    req_valid = 1'b1; req_key = 4'h5; req_hold_ms = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef KP_EMU_BOUNCE_EN
    repeat (BT * BC + 9) @(negedge clk);
`else
    repeat (9) @(negedge clk);
`endif
    check("pre_reset row_n", row_n, 4'b1101);
    #2 rst = 1'b1;
    #1;
    check("async_reset row_n", row_n, 4'hF);
    check("async_reset busy", busy, 0);
    check("async_reset key_active", key_active, 0);
    check("async_reset done", done, 0);
    check("async_reset ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_hold done", done, 0);
    @(negedge clk);
    check("ready_after_mid_reset", req_ready, 1);
    check("no_done_after_mid_reset", done, 0);
    check("idle_after_mid_reset busy", busy, 0);

    // Corner keys back to back, each next request waiting with valid high.
    issue(4'h1, 8'd1, 1'b1, 1'b1, 4'hA, 8'd1);
    @(posedge clk);
    measure(1'b1, 1'b1, 4'h0, 8'd1);
    @(posedge clk);
    measure(1'b1, 1'b1, 4'hD, 8'd1);
    @(posedge clk);
    measure(1'b1, 1'b0, 4'h0, 8'd0);

    // Hold of zero acts as 1 ms; hold of 255 must not wrap.
    col_n = 4'b1011;
    issue(4'h9, 8'd0, 1'b0, 1'b0, 4'h0, 8'd0);
    issue(4'hE, 8'd255, 1'b0, 1'b0, 4'h0, 8'd0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
